// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage FSM states.
// No logic; pure type definitions consumed by alu_exec and the decoder's users.
// Not applicable: no datapath, no handshake.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_MUL = 3'b011,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_t;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } alu_state_t;

endpackage

// File: rtl/alu_exec_if.sv
// Operand/result handshake bundle between the issue stage and alu_exec.
// Wires only; no added latency.
// master drives in_valid/out_ready, slave (the unit) drives in_ready/out_valid.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, alu_ctrl, a, b, out_ready,
        input  in_ready, out_valid, result, zero, err
    );

    modport slave (
        input  in_valid, alu_ctrl, a, b, out_ready,
        output in_ready, out_valid, result, zero, err
    );
endinterface

// File: rtl/serial_mul.sv
// Iterative shift-add multiplier, low WIDTH bits of the unsigned product.
// Latency: WIDTH step edges after start; done/product valid on the last step.
// No backpressure: the caller only starts it when it can take the product.
module serial_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_next;

    // product is the accumulator including the current step's partial product,
    // so the caller can capture it on the final step edge
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign product  = acc_next;
    assign done     = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: AND/OR/ADD/SUB/SLT, illegal-code flagging, serial MUL.
// Latency: 1 cycle for single-cycle codes, WIDTH+1 cycles for MUL.
// Holds result while out_ready is low; in_ready drops during MUL or a stalled result.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_exec_if.slave  bus
);
    alu_state_t       state;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             err_q;

    logic             accept;
    logic             is_mul;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] op_res;
    logic             op_err;

    assign bus.in_ready  = (state == S_IDLE) && !mul_busy &&
                           (!out_valid_q || bus.out_ready) && !reset;
    assign accept        = bus.in_valid && bus.in_ready;
    assign is_mul        = (bus.alu_ctrl == ALU_MUL);

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;

    always_comb begin
        op_res = '0;
        op_err = 1'b0;
        case (alu_ctrl_t'(bus.alu_ctrl))
            ALU_AND: op_res = bus.a & bus.b;
            ALU_OR:  op_res = bus.a | bus.b;
            ALU_ADD: op_res = bus.a + bus.b;
            ALU_SUB: op_res = bus.a - bus.b;
            ALU_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            ALU_MUL: op_res = '0;
            default: op_err = 1'b1;
        endcase
    end

    serial_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // a consumed result drops unless reloaded below on the same edge
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= S_MUL;
                        end else begin
                            result_q    <= op_res;
                            zero_q      <= (op_res == '0);
                            err_q       <= op_err;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        result_q    <= mul_product;
                        zero_q      <= (mul_product == '0);
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed literal cases plus randomized traffic checked
// every cycle against a transaction-level model of the unit.
module tb_alu_exec;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    alu_exec_if #(.WIDTH(W)) intf ();

    alu_exec #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // {err, zero, result} straight from the opcode table
    function automatic logic [W+1:0] ref_op(input logic [2:0] op, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        logic [W-1:0] r;
        logic [63:0]  p;
        logic         e;
        r = '0;
        e = 1'b0;
        p = 64'(x) * 64'(y);
        case (op)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b010: r = x + y;
            3'b110: r = x - y;
            3'b111: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            3'b011: r = p[W-1:0];
            default: e = 1'b1;
        endcase
        return {e, (r == '0), r};
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7fff_ffff;
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // transaction-level model: pending result plus remaining multiply cycles
    logic         m_vld = 1'b0;
    logic [W-1:0] m_res = '0;
    logic         m_zero = 1'b0;
    logic         m_err = 1'b0;
    int           m_left = 0;
    logic [W+1:0] m_mul = '0;
    logic         exp_rdy;
    logic [W+1:0] m_r;

    always @(negedge clk) begin
        exp_rdy = !reset && (m_left == 0) && (!m_vld || intf.out_ready);
        chk("out_valid", W'(intf.out_valid), W'(m_vld));
        chk("in_ready", W'(intf.in_ready), W'(exp_rdy));
        if (m_vld) begin
            chk("result", intf.result, m_res);
            chk("zero", W'(intf.zero), W'(m_zero));
            chk("err", W'(intf.err), W'(m_err));
        end
        if (reset) begin
            m_vld = 1'b0; m_res = '0; m_zero = 1'b0; m_err = 1'b0; m_left = 0;
        end else begin
            if (m_vld && intf.out_ready) m_vld = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    {m_err, m_zero, m_res} = m_mul;
                    m_vld = 1'b1;
                end
            end else if (intf.in_valid && exp_rdy) begin
                m_r = ref_op(intf.alu_ctrl, intf.a, intf.b);
                if (intf.alu_ctrl == ALU_MUL) begin
                    m_left = W;
                    m_mul  = m_r;
                end else begin
                    {m_err, m_zero, m_res} = m_r;
                    m_vld = 1'b1;
                end
            end
        end
    end

    // called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        bit ok = 0;
        intf.in_valid = 1'b1;
        intf.alu_ctrl = op;
        intf.a = x;
        intf.b = y;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (intf.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        intf.in_valid = 1'b0;
        intf.alu_ctrl = 3'($urandom);
        intf.a = $urandom;
        intf.b = $urandom;
    endtask

    task automatic wait_out(output int lat, output int low);
        bit seen = 0;
        lat = 0;
        low = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            lat++;
            if (intf.out_valid) begin
                seen = 1;
                break;
            end
            if (!intf.in_ready) low++;
        end
        if (!seen) chk("result_timeout", 0, 1);
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] er, input logic ez,
                          input logic ee, input int elat, input int elow);
        int lat, low;
        send(op, x, y);
        wait_out(lat, low);
        chk({nm, "_lat"}, W'(lat), W'(elat));
        chk({nm, "_stall"}, W'(low), W'(elow));
        chk({nm, "_res"}, intf.result, er);
        chk({nm, "_zero"}, W'(intf.zero), W'(ez));
        chk({nm, "_err"}, W'(intf.err), W'(ee));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, low, seen;
        intf.in_valid = 1'b0;
        intf.out_ready = 1'b1;
        intf.alu_ctrl = 3'b000;
        intf.a = '0;
        intf.b = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", W'(intf.in_ready), 0);
        chk("rst_out_valid", W'(intf.out_valid), 0);
        chk("rst_result", intf.result, 0);
        chk("rst_zero", W'(intf.zero), 0);
        chk("rst_err", W'(intf.err), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", W'(intf.in_ready), 1);
        @(posedge clk);
        #1;

        run_op("add_wrap", ALU_ADD, 32'hffff_ffff, 32'h1, 32'h0, 1'b1, 1'b0, 1, 0);
        run_op("slt_neg", ALU_SLT, 32'hffff_fffe, 32'h1, 32'h1, 1'b0, 1'b0, 1, 0);
        run_op("sub_neg", ALU_SUB, 32'd5, 32'd7, 32'hffff_fffe, 1'b0, 1'b0, 1, 0);
        run_op("mul", ALU_MUL, 32'd12345, 32'd678, 32'd8369910, 1'b0, 1'b0, 33, 32);
        run_op("illegal", 3'b101, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b1, 1, 0);

        // back-pressure, then replacement by a queued OR on the consuming edge
        intf.out_ready = 1'b0;
        send(ALU_ADD, 32'd3, 32'd4);
        wait_out(lat, low);
        chk("bp_lat", W'(lat), 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_res", intf.result, 32'd7);
            chk("bp_in_ready", W'(intf.in_ready), 0);
        end
        @(posedge clk);
        #1 intf.out_ready = 1'b1;
        send(ALU_OR, 32'h0000_00f0, 32'h0000_000f);
        @(negedge clk);
        chk("bp_replace_vld", W'(intf.out_valid), 1);
        chk("bp_replace_res", intf.result, 32'h0000_00ff);
        @(posedge clk);
        #1;

        // reset aborts a multiply in flight
        send(ALU_MUL, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", W'(intf.out_valid), 0);
        chk("abort_in_ready", W'(intf.in_ready), 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (intf.out_valid) seen++;
        end
        chk("abort_no_result", W'(seen), 0);
        @(posedge clk);
        #1;
        run_op("and_after_abort", ALU_AND, 32'h0000_f0f0, 32'h0000_0ff0, 32'h0000_00f0,
               1'b0, 1'b0, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            intf.in_valid  = ($urandom_range(0, 9) < 7);
            intf.alu_ctrl  = 3'($urandom_range(0, 7));
            intf.a         = rnd_val();
            intf.b         = rnd_val();
            intf.out_ready = ($urandom_range(0, 3) != 0);
            reset          = ($urandom_range(0, 199) == 0);
            @(posedge clk);
            #1;
        end

        intf.in_valid = 1'b0;
        intf.out_ready = 1'b1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
